// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the multi-word CLA sequencer.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cla_ctrl_state_t;

  // Index width for a slice counter; a single-slice build still gets one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_adder.sv
// N-bit carry-lookahead adder: every carry is a flat sum of generate terms
// qualified by the run of propagates below it, rather than a ripple chain.
module cla_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         acc;
  logic         prod;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_i.
  always_comb begin
    // NOTE: every variable gets a default before any loop or branch, so no path leaves one unassigned and no latch is inferred.
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    c[0] = c_i;
    for (int i = 0; i < N; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & c_i);
    end
  end

  assign s_o = p ^ c[N-1:0];
  assign c_o = c[N];

endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// Wide adder built from one shared N-bit CLA slice, stepped LS slice first,
// with the carry held in a register between slices and valid/ready on both sides.
module cla_multiword_add_ctrl
  import cla_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*WORDS-1:0] s,
  output logic             c_out,
  output logic             busy
);

  localparam int W  = N * WORDS;
  localparam int IW = clog2_min1(WORDS);

  cla_ctrl_state_t state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;     // working result, filled slice by slice
  logic [W-1:0]    s_q, s_d;         // presented sum, updated only on completion
  logic            cout_q, cout_d;   // presented carry-out

  logic [N-1:0]    slice_a;
  logic [N-1:0]    slice_b;
  logic [N-1:0]    slice_s;
  logic            slice_c;

  assign slice_a = a_q[idx_q*N +: N];
  assign slice_b = b_q[idx_q*N +: N];

  cla_adder #(.N(N)) u_slice_add (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  // Next-state and datapath update for accept, per-slice step and hand-off.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q*N +: N] = slice_s;
        carry_d             = slice_c;
        if (idx_q == IW'(WORDS - 1)) begin
          idx_d   = '0;
          s_d     = res_d;
          cout_d  = slice_c;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values regardless of statement order.
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign c_out     = cout_q;

endmodule

// File: doc/cla_multiword_add_ctrl.md
Name: cla_multiword_add_ctrl

Overview:
Sequencer that performs one wide addition of N*WORDS bits using a single shared N-bit cla_adder instance, one slice per clock, least-significant slice first.
- The carry is chained through a register between slices.
- Valid/ready handshakes on the operand side and on the result side.
- Sits between operand producers and consumers wherever a full-width combinational CLA is too large or too slow.

Parameters:
N, 8, slice width in bits; width of the internal cla_adder.
WORDS, 4, number of slices; total operand width W = N*WORDS; legal range 1..64.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operand request valid.
in_ready  output  1  controller can accept an operand request.
a  input  N*WORDS  operand A; sampled only on accept.
b  input  N*WORDS  operand B; sampled only on accept.
c_in  input  1  carry-in; sampled only on accept.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
s  output  N*WORDS  sum (a + b + c_in) mod 2^W.
c_out  output  1  carry out of bit W-1.
busy  output  1  high in RUN or DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE. The state type is an enum.
- Reset, applied at any clock edge including mid-RUN or in DONE:
  - state=IDLE, slice index=0, carry register=0, operand registers=0, result register=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, s=0, c_out=0.
  - Any in-flight operation is discarded silently.
- IDLE:
  - in_ready=1.
  - On in_valid=1 (accept):
    - Latch a, b and c_in.
    - Set carry register=c_in and index=0.
    - Next state RUN.
  - in_valid=0: stay in IDLE; registers are unchanged.
- RUN:
  - in_ready=0; in_valid is ignored, and a/b/c_in changes have no effect.
  - The cla_adder is driven with a_reg[idx*N +: N], b_reg[idx*N +: N] and the carry register.
  - Each edge:
    - Result slice idx is written with the adder s.
    - Carry register takes the adder c_out.
    - idx increments.
  - When idx==WORDS-1 at the edge, next state is DONE and idx returns to 0.
- DONE:
  - out_valid=1; s=result register; c_out=carry register.
  - Outputs stay stable while out_ready=0, for an unbounded hold.
  - On out_ready=1: next state IDLE, out_valid=0 the next cycle. s and c_out keep their last value until the next DONE.
- Latency: out_valid rises exactly WORDS cycles after the accept edge.
- Throughput: with out_ready tied high, one operation every WORDS+2 cycles. No overlap between operations.
- Index width is $clog2(WORDS), minimum 1. Ranges for idx are always in bounds.
- WORDS=1: RUN lasts exactly one cycle.
- Arithmetic is unsigned modulo 2^W. Overflow is reported only through c_out.
- s, c_out, out_valid and in_ready are driven from registers or state decode. There is no combinational path from in_valid or out_ready to any output.

Decomposition:
- Package cla_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cla_ctrl_state_t;
  - localparam function clog2_min1 for the index width.
- Sub-module: the existing cla_adder #(.N(N)), one instance named u_slice_add.
  - Its inputs are the slice muxes and the carry register; no other arithmetic is in the controller.

Test Plan:
N=8, WORDS=4, a=32'hFFFFFFFF, b=32'h1, c_in=0, out_ready=1 -> out_valid high 4 cycles after accept; s=32'h00000000, c_out=1; in_ready back to 1 one cycle later.

a=32'h12345678, b=32'h11111111, c_in=0 -> s=32'h23456789, c_out=0. Then a=b=32'h7FFFFFFF, c_in=1 -> s=32'hFFFFFFFF, c_out=0.

Backpressure: a=32'h80000000, b=32'h80000000, out_ready=0 for 6 cycles in DONE -> s=0 and c_out=1 held constant, out_valid stays 1. Raise out_ready -> out_valid=0 on the next cycle.

During RUN, toggle in_valid and change a/b to random values every cycle -> in_ready=0 throughout, and the result equals the sum of the originally accepted operands.

Reset asserted for 1 cycle at RUN slice 2 -> the next cycle shows state IDLE, in_ready=1, out_valid=0, s=0, c_out=0. A following op with a=5, b=7 gives s=12.

Alternate build N=2, WORDS=1: a=2'b11, b=2'b11, c_in=0 -> out_valid 1 cycle after accept, s=2'b10, c_out=1. Then sweep all 32 combinations of a, b and c_in against a reference model.
